// File: rtl/avmm_pipe_bridge.sv
// Avalon-MM pipeline bridge: command FIFO with a registered master stage,
// a cap on outstanding read beats and a registered read-response path.
module avmm_pipe_bridge #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 28,
  parameter int BURST_W   = 1,
  parameter int CMD_DEPTH = 4,
  parameter int MAX_PEND  = 8
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset,

  input  logic [ADDR_W-1:0]              s_address,
  input  logic                           s_read,
  input  logic                           s_write,
  input  logic [DATA_W-1:0]              s_writedata,
  input  logic [DATA_W/8-1:0]            s_byteenable,
  input  logic [BURST_W-1:0]             s_burstcount,
  input  logic                           s_debugaccess,
  output logic                           s_waitrequest,
  output logic [DATA_W-1:0]              s_readdata,
  output logic                           s_readdatavalid,

  output logic [ADDR_W-1:0]              m_address,
  output logic                           m_read,
  output logic                           m_write,
  output logic [DATA_W-1:0]              m_writedata,
  output logic [DATA_W/8-1:0]            m_byteenable,
  output logic [BURST_W-1:0]             m_burstcount,
  output logic                           m_debugaccess,
  input  logic                           m_waitrequest,
  input  logic [DATA_W-1:0]              m_readdata,
  input  logic                           m_readdatavalid,

  output logic [$clog2(MAX_PEND+1)-1:0]  pend_cnt,
  output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_level,
  output logic                           err_orphan
);

  localparam int BE_W   = DATA_W / 8;
  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam int LVL_W  = $clog2(CMD_DEPTH + 1);
  localparam int PTR_W  = LVL_W - 1;
  localparam int SUM_W  = PEND_W + BURST_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic               rd;
    logic               wr;
    logic [DATA_W-1:0]  wdata;
    logic [BE_W-1:0]    be;
    logic [BURST_W-1:0] bc;
    logic               dbg;
  } cmd_t;

  cmd_t mem_q [CMD_DEPTH];

  logic [LVL_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               s_waitrequest_q;
  logic [DATA_W-1:0]  s_readdata_q;
  logic               s_readdatavalid_q;
  logic               err_orphan_q;

  logic [ADDR_W-1:0]  m_addr_q;
  logic               m_read_q;
  logic               m_write_q;
  logic [DATA_W-1:0]  m_wdata_q;
  logic [BE_W-1:0]    m_be_q;
  logic [BURST_W-1:0] m_bc_q;
  logic               m_dbg_q;

  logic               push, pop, issue_rd, rsp_ok, orphan;
  cmd_t               push_ent, cand;
  logic [PTR_W-1:0]   cand_idx;
  logic               cand_avail, cand_block, stage_free, fire;
  logic [SUM_W-1:0]   pend_sum, cand_sum;

  assign push     = (s_read | s_write) & ~s_waitrequest_q;
  assign pop      = (m_read_q | m_write_q) & ~m_waitrequest;
  assign issue_rd = m_read_q & ~m_waitrequest;
  assign rsp_ok   = m_readdatavalid & (pend_q != '0);
  assign orphan   = m_readdatavalid & (pend_q == '0);

  // A simultaneous read+write is kept as the write; burstcount 0 becomes 1.
  always_comb begin
    push_ent       = '0;
    push_ent.addr  = s_address;
    push_ent.rd    = s_read & ~s_write;
    push_ent.wr    = s_write;
    push_ent.wdata = s_writedata;
    push_ent.be    = s_byteenable;
    push_ent.bc    = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
    push_ent.dbg   = s_debugaccess;
  end

  assign wr_ptr_d = wr_ptr_q + LVL_W'(push);
  assign rd_ptr_d = rd_ptr_q + LVL_W'(pop);
  assign level_q  = wr_ptr_q - rd_ptr_q;
  assign level_d  = wr_ptr_d - rd_ptr_d;

  assign pend_sum = SUM_W'(pend_q)
                  + (issue_rd ? SUM_W'(m_bc_q) : SUM_W'(0))
                  - SUM_W'(rsp_ok);
  assign pend_d   = pend_sum[PEND_W-1:0];

  // The master stage reloads from the entry that will be at the head after
  // this edge; a same-cycle push is never bypassed into the stage.
  assign cand_idx   = rd_ptr_q[PTR_W-1:0] + PTR_W'(pop);
  assign cand       = mem_q[cand_idx];
  assign cand_avail = pop ? (level_q >= LVL_W'(2)) : (level_q != '0);
  assign cand_sum   = SUM_W'(pend_d) + SUM_W'(cand.bc);
  assign cand_block = cand.rd & (cand_sum > SUM_W'(MAX_PEND));
  assign stage_free = ~((m_read_q | m_write_q) & m_waitrequest);
  assign fire       = stage_free & cand_avail & ~cand_block;

  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_ent;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      pend_q            <= '0;
      s_waitrequest_q   <= 1'b1;
      s_readdata_q      <= '0;
      s_readdatavalid_q <= 1'b0;
      err_orphan_q      <= 1'b0;
      m_addr_q          <= '0;
      m_read_q          <= 1'b0;
      m_write_q         <= 1'b0;
      m_wdata_q         <= '0;
      m_be_q            <= '0;
      m_bc_q            <= '0;
      m_dbg_q           <= 1'b0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      pend_q            <= pend_d;
      s_waitrequest_q   <= (level_d == LVL_W'(CMD_DEPTH));
      s_readdata_q      <= m_readdata;
      s_readdatavalid_q <= rsp_ok;
      err_orphan_q      <= err_orphan_q | orphan;
      if (stage_free) begin
        m_read_q  <= fire & cand.rd;
        m_write_q <= fire & cand.wr;
        if (fire) begin
          m_addr_q  <= cand.addr;
          m_wdata_q <= cand.wdata;
          m_be_q    <= cand.be;
          m_bc_q    <= cand.bc;
          m_dbg_q   <= cand.dbg;
        end
      end
    end
  end

  assign s_waitrequest   = s_waitrequest_q;
  assign s_readdata      = s_readdata_q;
  assign s_readdatavalid = s_readdatavalid_q;
  assign m_address       = m_addr_q;
  assign m_read          = m_read_q;
  assign m_write         = m_write_q;
  assign m_writedata     = m_wdata_q;
  assign m_byteenable    = m_be_q;
  assign m_burstcount    = m_bc_q;
  assign m_debugaccess   = m_dbg_q;
  assign pend_cnt        = pend_q;
  assign cmd_level       = level_q;
  assign err_orphan      = err_orphan_q;

endmodule

// File: tb/tb_avmm_pipe_bridge.sv
// Bench for avmm_pipe_bridge: vector table, corner-case sequences and random
// traffic checked against a transaction-level queue model.
module tb_avmm_pipe_bridge;

  localparam int DW    = 32;
  localparam int AW    = 28;
  localparam int BW    = 4;
  localparam int DEPTH = 4;
  localparam int MAXP  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] s_address;
  logic          s_read, s_write;
  logic [DW-1:0] s_writedata;
  logic [3:0]    s_byteenable;
  logic [BW-1:0] s_burstcount;
  logic          s_debugaccess;
  logic          s_waitrequest;
  logic [DW-1:0] s_readdata;
  logic          s_readdatavalid;
  logic [AW-1:0] m_address;
  logic          m_read, m_write;
  logic [DW-1:0] m_writedata;
  logic [3:0]    m_byteenable;
  logic [BW-1:0] m_burstcount;
  logic          m_debugaccess;
  logic          m_waitrequest;
  logic [DW-1:0] m_readdata;
  logic          m_readdatavalid;
  logic [3:0]    pend_cnt;
  logic [2:0]    cmd_level;
  logic          err_orphan;

  avmm_pipe_bridge #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .CMD_DEPTH(DEPTH), .MAX_PEND(MAXP)
  ) dut (
    .clk_clk(clk), .reset_reset(rst),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_burstcount(s_burstcount), .s_debugaccess(s_debugaccess),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_burstcount(m_burstcount), .m_debugaccess(m_debugaccess),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .pend_cnt(pend_cnt), .cmd_level(cmd_level), .err_orphan(err_orphan)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic [BW-1:0] bc;
    logic          dbg;
  } cmd_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic [BW-1:0] bc;
    logic          dbg;
    logic          exp_rd;
    logic          exp_wr;
    logic [BW-1:0] exp_bc;
  } vec_t;

  cmd_t          exp_q[$];
  logic [DW-1:0] iss_wd[$];
  int            pend_m;
  logic          orphan_m;
  logic          exp_srdv;
  logic [DW-1:0] exp_sdata;
  logic          last_acc;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_m   = 0;
    orphan_m = 1'b0;
    exp_srdv = 1'b0;
  endtask

  task automatic idle_cmd();
    s_read  = 1'b0;
    s_write = 1'b0;
  endtask

  task automatic set_cmd(input logic [AW-1:0] a, input logic rd, input logic wr,
                         input logic [DW-1:0] d, input logic [BW-1:0] bc, input logic dbg);
    s_address     = a;
    s_read        = rd;
    s_write       = wr;
    s_writedata   = d;
    s_byteenable  = 4'hF;
    s_burstcount  = bc;
    s_debugaccess = dbg;
  endtask

  // One clock: sample pre-edge handshakes, advance, then update and check the model.
  task automatic step();
    logic          acc, iss, stall, rdv, have_e;
    cmd_t          c, ic, e;
    logic [DW-1:0] rdata;
    int            pend_pre, rd_bc;
    acc      = (s_read || s_write) && !s_waitrequest && !rst;
    iss      = (m_read || m_write) && !m_waitrequest;
    stall    = (m_read || m_write) && m_waitrequest;
    c.addr   = s_address;
    c.rd     = s_read && !s_write;
    c.wr     = s_write;
    c.wdata  = s_writedata;
    c.be     = s_byteenable;
    c.bc     = (s_burstcount == 0) ? BW'(1) : s_burstcount;
    c.dbg    = s_debugaccess;
    ic.addr  = m_address;
    ic.rd    = m_read;
    ic.wr    = m_write;
    ic.wdata = m_writedata;
    ic.be    = m_byteenable;
    ic.bc    = m_burstcount;
    ic.dbg   = m_debugaccess;
    rdv      = m_readdatavalid;
    rdata    = m_readdata;
    @(posedge clk);
    #1;
    last_acc = acc;
    if (rst) begin
      model_clear();
      return;
    end
    if (stall)
      chk("hold_stable",
          {m_address, m_read, m_write, m_writedata, m_byteenable, m_burstcount, m_debugaccess},
          {ic.addr, ic.rd, ic.wr, ic.wdata, ic.be, ic.bc, ic.dbg});
    have_e = 1'b0;
    rd_bc  = 0;
    if (iss) begin
      if (exp_q.size() == 0) begin
        chk("issue_unexpected", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        have_e = 1'b1;
        chk("issue_cmd", {ic.addr, ic.rd, ic.wr, ic.bc, ic.dbg},
            {e.addr, e.rd, e.wr, e.bc, e.dbg});
        chk("issue_data", {ic.wdata, ic.be}, {e.wdata, e.be});
        if (e.wr) iss_wd.push_back(ic.wdata);
        if (e.rd) rd_bc = int'(e.bc);
      end
    end
    pend_pre = pend_m;
    if (have_e && e.rd) chk("throttle_limit", (pend_pre + rd_bc) <= MAXP, 1'b1);
    exp_srdv  = rdv && (pend_pre != 0);
    exp_sdata = rdata;
    if (rdv && pend_pre == 0) orphan_m = 1'b1;
    pend_m = pend_pre + rd_bc - (exp_srdv ? 1 : 0);
    if (acc) exp_q.push_back(c);
    chk("cmd_level", cmd_level, exp_q.size());
    chk("pend_cnt", pend_cnt, pend_m);
    chk("s_waitrequest", s_waitrequest, exp_q.size() == DEPTH);
    chk("s_readdatavalid", s_readdatavalid, exp_srdv);
    if (exp_srdv) chk("s_readdata", s_readdata, exp_sdata);
    chk("err_orphan", err_orphan, orphan_m);
  endtask

  task automatic drain(input int budget);
    idle_cmd();
    m_waitrequest = 1'b0;
    for (int k = 0; k < budget; k++) begin
      m_readdatavalid = (pend_m > 0);
      m_readdata      = $urandom;
      step();
      if (exp_q.size() == 0 && pend_m == 0) break;
    end
    m_readdatavalid = 1'b0;
    chk("drain_level", cmd_level, 0);
    chk("drain_pend", pend_cnt, 0);
  endtask

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{28'h0000010, 1'b1, 1'b0, 32'h0,         4'hF, 4'd1, 1'b0, 1'b1, 1'b0, 4'd1};
    vecs[1] = '{28'h0000020, 1'b0, 1'b1, 32'h1234_5678, 4'h3, 4'd1, 1'b0, 1'b0, 1'b1, 4'd1};
    vecs[2] = '{28'hABCDEF0, 1'b1, 1'b1, 32'hCAFE_F00D, 4'hF, 4'd1, 1'b1, 1'b0, 1'b1, 4'd1};
    vecs[3] = '{28'h0000100, 1'b1, 1'b0, 32'h0,         4'hF, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1};
    vecs[4] = '{28'hFFFFFFC, 1'b0, 1'b1, 32'h0BAD_0BAD, 4'hC, 4'd0, 1'b1, 1'b0, 1'b1, 4'd1};
    vecs[5] = '{28'h0000200, 1'b1, 1'b0, 32'h0,         4'hF, 4'd8, 1'b1, 1'b1, 1'b0, 4'd8};
    vecs[6] = '{28'h0000240, 1'b1, 1'b0, 32'h0,         4'h1, 4'd4, 1'b0, 1'b1, 1'b0, 4'd4};

    rst = 1'b0;
    set_cmd('0, 1'b0, 1'b0, '0, '0, 1'b0);
    s_byteenable    = '0;
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata      = '0;
    last_acc        = 1'b0;
    model_clear();

    // Reset values and release timing.
    #2 rst = 1'b1;
    #1;
    chk("rst_wait", s_waitrequest, 1'b1);
    chk("rst_mcmd", {m_read, m_write, m_address}, '0);
    chk("rst_level", cmd_level, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_resp", {s_readdatavalid, err_orphan}, 2'b00);
    step();
    rst = 1'b0;
    step();
    chk("release_wait", s_waitrequest, 1'b0);

    // Single-command vectors; reads return data 3 cycles after m_read.
    foreach (vecs[i]) begin
      set_cmd(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, vecs[i].bc, vecs[i].dbg);
      s_byteenable = vecs[i].be;
      step();
      chk($sformatf("vec%0d_acc", i), last_acc, 1'b1);
      idle_cmd();
      chk($sformatf("vec%0d_early", i), {m_read, m_write}, 2'b00);
      step();
      chk($sformatf("vec%0d_mcmd", i),
          {m_read, m_write, m_burstcount, m_address, m_debugaccess, m_byteenable},
          {vecs[i].exp_rd, vecs[i].exp_wr, vecs[i].exp_bc, vecs[i].addr, vecs[i].dbg, vecs[i].be});
      if (vecs[i].exp_wr) chk($sformatf("vec%0d_wdata", i), m_writedata, vecs[i].wdata);
      step();
      if (vecs[i].exp_rd) begin
        chk($sformatf("vec%0d_pend_issue", i), pend_cnt, vecs[i].exp_bc);
        step();
        for (int b = 0; b < int'(vecs[i].exp_bc); b++) begin
          m_readdatavalid = 1'b1;
          m_readdata      = 32'hDEAD_BEEF + b;
          step();
          m_readdatavalid = 1'b0;
          chk($sformatf("vec%0d_rdata", i), {s_readdatavalid, s_readdata},
              {1'b1, 32'hDEAD_BEEF + b});
        end
        chk($sformatf("vec%0d_pend_done", i), pend_cnt, 0);
      end
    end

    // FIFO fill under downstream backpressure.
    m_waitrequest = 1'b1;
    iss_wd.delete();
    for (int d = 1; d <= 4; d++) begin
      set_cmd(AW'(d * 4), 1'b0, 1'b1, DW'(d), 4'd1, 1'b0);
      step();
      chk("fill_acc", last_acc, 1'b1);
    end
    chk("fill_wait", s_waitrequest, 1'b1);
    chk("fill_level", cmd_level, 4);
    set_cmd(AW'(20), 1'b0, 1'b1, DW'(5), 4'd1, 1'b0);
    step();
    chk("fill_blocked", last_acc, 1'b0);
    step();
    m_waitrequest = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (last_acc) idle_cmd();
      if (iss_wd.size() == 5) break;
    end
    idle_cmd();
    chk("fill_count", iss_wd.size(), 5);
    for (int j = 0; j < 5; j++)
      if (j < iss_wd.size()) chk("fill_order", iss_wd[j], j + 1);

    // Throttle: bc 8 read fills the budget, bc 1 read waits for a beat.
    set_cmd(28'h300, 1'b1, 1'b0, '0, 4'd8, 1'b0);
    step();
    set_cmd(28'h340, 1'b1, 1'b0, '0, 4'd1, 1'b0);
    step();
    idle_cmd();
    step();
    chk("thr_pend8", pend_cnt, 8);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("thr_hold", {m_read, pend_cnt}, {1'b0, 4'd8});
    end
    m_readdatavalid = 1'b1;
    step();
    m_readdatavalid = 1'b0;
    chk("thr_pend7", pend_cnt, 7);
    chk("thr_release", {m_read, m_burstcount, m_address}, {1'b1, 4'd1, 28'h340});
    step();
    chk("thr_pend8_again", pend_cnt, 8);
    drain(40);

    // Issue of a bc 2 read in the same cycle as a returning beat.
    set_cmd(28'h400, 1'b1, 1'b0, '0, 4'd3, 1'b0);
    step();
    set_cmd(28'h410, 1'b1, 1'b0, '0, 4'd2, 1'b0);
    step();
    idle_cmd();
    step();
    chk("simul_pre", {pend_cnt, m_read, m_burstcount}, {4'd3, 1'b1, 4'd2});
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h0000_A5A5;
    step();
    m_readdatavalid = 1'b0;
    chk("simul_pend", pend_cnt, 4);
    drain(40);

    // Orphan response.
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h5555_5555;
    step();
    m_readdatavalid = 1'b0;
    chk("orphan_rdv", s_readdatavalid, 1'b0);
    chk("orphan_err", err_orphan, 1'b1);
    repeat (3) step();
    chk("orphan_sticky", err_orphan, 1'b1);

    // Reset with 3 commands queued and 2 beats pending.
    set_cmd(28'h500, 1'b1, 1'b0, '0, 4'd2, 1'b0);
    step();
    idle_cmd();
    step();
    step();
    m_waitrequest = 1'b1;
    for (int d = 0; d < 3; d++) begin
      set_cmd(AW'(28'h600 + d * 4), 1'b0, 1'b1, DW'(32'h100 + d), 4'd1, 1'b0);
      step();
    end
    idle_cmd();
    chk("mid_level", cmd_level, 3);
    chk("mid_pend", pend_cnt, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_level", cmd_level, 0);
    chk("mid_rst_pend", pend_cnt, 0);
    chk("mid_rst_wait", s_waitrequest, 1'b1);
    chk("mid_rst_outs", {m_read, m_write, s_readdatavalid, err_orphan}, 4'b0000);
    model_clear();
    m_waitrequest = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("mid_release", s_waitrequest, 1'b0);
    m_readdatavalid = 1'b1;
    step();
    m_readdatavalid = 1'b0;
    chk("late_beat_err", err_orphan, 1'b1);
    chk("late_beat_rdv", s_readdatavalid, 1'b0);

    rst = 1'b1;
    #1;
    model_clear();
    step();
    rst = 1'b0;
    step();

    // Random traffic against the queue model.
    begin
      logic have_cmd;
      int   kind;
      have_cmd = 1'b0;
      last_acc = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if (!have_cmd || last_acc) begin
          if ($urandom_range(0, 9) < 6) begin
            kind = $urandom_range(0, 9);
            set_cmd(AW'($urandom), kind < 4 || kind >= 8, kind >= 4, $urandom,
                    BW'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
            s_byteenable = 4'($urandom);
            have_cmd = 1'b1;
          end else begin
            idle_cmd();
            have_cmd = 1'b0;
          end
        end
        m_waitrequest   = ($urandom_range(0, 9) < 3);
        m_readdatavalid = (pend_m > 0) && ($urandom_range(0, 2) != 0);
        m_readdata      = $urandom;
        step();
      end
    end
    drain(300);
    chk("final_no_orphan", err_orphan, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
